serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer built around the team's one-bit full_adder (ports a, b, cin, y, cout).
- Latches two WIDTH-bit operands on a start handshake, then drives the single full_adder one bit per clock, LSB first, through a carry flip-flop.
- Presents the result with a done pulse.
- Area-minimal arithmetic unit for lab datapaths that trade latency for one adder cell.

---
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder cell is reused once per clock,
// LSB first, with the carry held in a flip-flop between bits.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic y,
   output logic cout
);
   assign y    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cmsb_q, cmsb_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             fa_y, fa_cout;

   full_adder u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .y    (fa_y),
      .cout (fa_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         part_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cmsb_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         part_q  <= part_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cmsb_q  <= cmsb_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      part_d  = part_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cmsb_d  = cmsb_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            part_d  = {fa_y, part_q[WIDTH-1:1]};
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            carry_d = fa_cout;
            // Last bit: carry_q is the carry into the MSB, needed for overflow.
            if (cnt_q == LAST) begin
               cmsb_d  = carry_q;
               sum_d   = {fa_y, part_q[WIDTH-1:1]};
               cout_d  = fa_cout;
               ovf_d   = carry_q ^ fa_cout;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl against an arithmetic reference model.

module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] prev_sum = '0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word two's-complement arithmetic.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                        input logic mc, output logic [W-1:0] es, output logic ec, output logic eo);
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb   = ms ? ~mb : mb;
      full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
      es   = full[W-1:0];
      ec   = full[W];
      eo   = (ma[W-1] == bb[W-1]) && (es[W-1] != ma[W-1]);
   endtask

   // Accepts one operation, checks busy/done timing and the landed result.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tc, input logic [W-1:0] es,
                         input logic ec, input logic eo);
      @(negedge clk);
      a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      chk({tag, "_sumhold"}, {24'd0, sum}, {24'd0, prev_sum});
      for (int i = 1; i < W; i++) begin
         @(negedge clk);
         if (!busy || done) chk({tag, "_busyrun"}, {30'd0, busy, done}, 32'd2);
      end
      @(negedge clk);
      chk({tag, "_done"}, {30'd0, busy, done}, 32'd1);
      chk({tag, "_sum"}, {23'd0, cout, sum}, {23'd0, ec, es});
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
      prev_sum = es;
      @(negedge clk);
      chk({tag, "_doneoff"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] es, first_sum;
      logic ec, eo, first_cout, first_ovf;
      int n;

      #1;
      chk("reset_outs", {20'd0, busy, done, cout, ovf, sum}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
      run_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("cin", 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
      run_op("sub", 8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0);
      run_op("subovf", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

      // Held start with changing operands during RUN and DONE.
      @(negedge clk);
      a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 8'h40; b = 8'h05; cin = 1'b1;
      for (int i = 1; i < W; i++) @(negedge clk);
      @(negedge clk);
      chk("held_done1", {30'd0, busy, done}, 32'd1);
      chk("held_sum1", {23'd0, cout, sum}, 32'h33);
      @(negedge clk);
      chk("held_nodup", {31'd0, done}, 32'd0);
      n = 0;
      while (!busy && n < 5) begin
         @(negedge clk);
         n++;
      end
      chk("held_accept", {31'd0, busy}, 32'd1);
      start = 1'b0;
      for (int i = 1; i < W; i++) begin
         @(negedge clk);
         if (!busy || done) chk("held_busy2", {30'd0, busy, done}, 32'd2);
      end
      @(negedge clk);
      chk("held_done2", {30'd0, busy, done}, 32'd1);
      chk("held_sum2", {23'd0, cout, sum}, 32'h46);
      prev_sum = 8'h46;

      // Hold: outputs frozen while idle.
      first_sum = sum; first_cout = cout; first_ovf = ovf;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold", {22'd0, done, busy, first_cout ^ cout, first_ovf ^ ovf, first_sum ^ sum}, 32'd0);
      end

      // Randomized operations against the model.
      for (int k = 0; k < 30; k++) begin
         logic [W-1:0] ra, rb;
         logic rs, rc;
         ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
         model(ra, rb, rs, rc, es, ec, eo);
         run_op("rand", ra, rb, rs, rc, es, ec, eo);
      end

      // Asynchronous reset three cycles into an operation.
      @(negedge clk);
      a = 8'hC3; b = 8'h5A; sub = 1'b0; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_async", {20'd0, busy, done, cout, ovf, sum}, 32'd0);
      @(negedge clk);
      chk("rst_held", {20'd0, busy, done, cout, ovf, sum}, 32'd0);
      rst = 1'b0;
      prev_sum = '0;
      run_op("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
